// File: rtl/pc_gen.sv
// Fetch-stage program counter: picks the next PC from trap, redirect, BTB prediction or
// sequential increment. The optional direct-mapped BTB is built only when PC_BTB_EN is defined.
module pc_gen #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               INC          = 4,
    parameter int               BTB_ENTRIES  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    output logic            pred_taken,
    output logic            pc_misaligned,
    output logic [1:0]      dbg_state_o
);

    localparam int              LOG_INC = $clog2(INC);
    localparam int              IDX     = $clog2(BTB_ENTRIES);
    localparam int              TAG_W   = XLEN - LOG_INC - IDX;
    localparam logic [XLEN-1:0] INC_V   = XLEN'(INC);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] seq;
    logic            rdr;

    assign rdr = trap_valid | redirect_valid;
    assign tgt = trap_valid ? trap_pc : redirect_pc;
    assign seq = pred_taken ? btb_target : pc_q + INC_V;

    // Handshake: a request is valid while fetch_valid is high and completes on the cycle
    // fetch_ready is also high; pc_out must not move until then.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        fetch_valid = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (rdr) pc_d = tgt;
            end
            RUN: begin
                fetch_valid = pc_write;
                if (rdr) begin
                    if (!pc_write || fetch_ready) begin
                        pc_d = tgt;
                    end else begin
                        pend_pc_d = tgt;
                        state_d   = PEND;
                    end
                end else if (pc_write && fetch_ready) begin
                    pc_d = seq;
                end
            end
            PEND: begin
                fetch_valid = pc_write;
                if (rdr) pend_pc_d = tgt;
                if (!pc_write || fetch_ready) begin
                    pc_d    = rdr ? tgt : pend_pc_q;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_misaligned = |pc_q[LOG_INC-1:0];
    assign dbg_state_o   = state_q;

`ifdef PC_BTB_EN
    logic [BTB_ENTRIES-1:0] btb_vld_q;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
    logic [IDX-1:0]         lk_idx, up_idx;
    logic [TAG_W-1:0]       lk_tag, up_tag;
    logic                   unused_upd_lsb;

    assign lk_idx         = pc_q[LOG_INC+IDX-1:LOG_INC];
    assign lk_tag         = pc_q[XLEN-1:LOG_INC+IDX];
    assign up_idx         = upd_pc[LOG_INC+IDX-1:LOG_INC];
    assign up_tag         = upd_pc[XLEN-1:LOG_INC+IDX];
    assign unused_upd_lsb = ^upd_pc[LOG_INC-1:0];

    // Lookup reads registered contents, so a same-cycle update shows up one cycle later.
    assign pred_taken = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign btb_target = btb_tgt_q[lk_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_vld_q <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                btb_vld_q[up_idx] <= 1'b1;
            end else if (btb_tag_q[up_idx] == up_tag) begin
                btb_vld_q[up_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag_q[up_idx] <= up_tag;
            btb_tgt_q[up_idx] <= upd_target;
        end
    end
`else
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign pred_taken = 1'b0;
    assign btb_target = '0;
`endif

endmodule
